alu_arb: RTL
============

ALU_ARB -- requirements
Module: alu_arb

Interface
REQ-001 Parameter PRIO_INIT, default 0, SHALL select the requester that wins the first arbitration after reset when both request.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 rN_req_valid  input  1  requester N (N=0,1) presents an operation.
REQ-005 rN_req_ready  output  1  operation from requester N accepted this cycle.
REQ-006 rN_req_a, rN_req_b  input  32 each  operands from requester N.
REQ-007 rN_req_ctr  input  4  ALU control code from requester N, passed through unmodified.
REQ-008 rN_rsp_valid  output  1  result for requester N held valid.
REQ-009 rN_rsp_ready  input  1  requester N consumes the result.
REQ-010 rN_rsp_out  output  32  registered ALU result.
REQ-011 rN_rsp_less, rN_rsp_zero  output  1 each  registered ALU less/zero flags.
REQ-012 alu_a, alu_b  output  32 each  operands driven to the shared ALU.
REQ-013 alu_ctr  output  4  control driven to the shared ALU.
REQ-014 alu_out  input  32; alu_less, alu_zero  input  1 each  combinational ALU results, valid in the same cycle.

Function
REQ-015 States SHALL be IDLE, RESP0, RESP1; RESPN means one result is held for requester N.
REQ-016 An accept slot SHALL exist when state is IDLE, or when state is RESPN and rN_rsp_valid & rN_rsp_ready in that cycle.
REQ-017 In an accept slot, with exactly one rN_req_valid high, that requester SHALL be granted.
REQ-018 In an accept slot, with both valid, the requester not granted most recently SHALL win (round-robin); the last-grant pointer SHALL update only on an actual grant.
REQ-019 The granted requester's a/b/ctr SHALL drive alu_a/alu_b/alu_ctr combinationally in the grant cycle; rN_req_ready SHALL be high for exactly that requester, that cycle.
REQ-020 With no grant, alu_a, alu_b and alu_ctr SHALL be driven to zero.
REQ-021 On a grant, alu_out/alu_less/alu_zero SHALL be captured at the clock edge and the next state SHALL be RESPg (latency 1 cycle: request accepted in cycle t, response valid in t+1).
REQ-022 rN_rsp_* outputs SHALL hold stable while in RESPN until consumed; the outputs of the other requester SHALL read zero with rsp_valid low.
REQ-023 RESPN with rsp consumed and no grant SHALL return to IDLE; with a grant, state SHALL move to RESPg (back-to-back throughput of one operation per cycle).
REQ-024 rN_req_ready SHALL NOT depend on rN_req_valid of the same requester except through the grant decision (no ready-valid combinational loop beyond the arbiter).
REQ-025 A requester with valid high and not granted SHALL keep its operands stable; the block SHALL not capture them.

Reset
REQ-026 rst high SHALL force state IDLE, all rsp_valid low, all rsp data/flags zero, last-grant pointer to NOT PRIO_INIT, and (if compiled) all counters zero; rst mid-response SHALL discard the held result.
REQ-027 While rst is high, all req_ready SHALL be low and ALU outputs zero.

Configuration
REQ-028 Macro ALU_ARB_PERF_CNT_EN defined: outputs grant_cnt0, grant_cnt1 (32 bits, +1 per grant to that requester) and conflict_cnt (32 bits, +1 per accept slot with both valid) SHALL exist, wrapping 0xFFFFFFFF->0.
REQ-029 Macro undefined: those ports and their registers SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-030 Shared package alu_arb_pkg SHALL hold XLEN=32, CTR_W=4 and the state encoding (IDLE, RESP0, RESP1).
REQ-031 A sub-module rr_arb2 (two requests, last-grant pointer in, one-hot grant out, combinational) SHALL implement REQ-017/018.

Verification (ALU stub computes a+b, less=(a<b), zero=(sum==0))
REQ-032 Single: r0 valid a=5 b=7 -> r0_req_ready same cycle; next cycle r0_rsp_valid, out=12, less=1, zero=0.
REQ-033 Contention: both valid after reset with PRIO_INIT=0 -> r0 granted first, r1 granted in the cycle r0 response is consumed; conflict_cnt=1.
REQ-034 Back-pressure: r1 rsp_ready low 3 cycles, a=0 b=0 -> rsp out=0, zero=1 held stable 3 cycles; r0 request not accepted meanwhile.
REQ-035 Streaming: r0 valid 4 consecutive ops, rsp_ready tied high -> 4 results on 4 consecutive cycles, grant_cnt0=4.
REQ-036 Reset mid-response: rst in RESP1 -> next cycle all rsp_valid low, out=0, state IDLE, counters 0.
REQ-037 Wrap: grant_cnt0 preloaded via force to 0xFFFFFFFF, one grant -> 0x00000000.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// rtl/alu_arb_pkg.sv - shared widths, FSM encoding and held-response type for alu_arb
package alu_arb_pkg;

    localparam int XLEN  = 32;
    localparam int CTR_W = 4;

    // FSM encoding: RESPn means one result is held for requester n
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RESP0 = 2'd1;
    localparam logic [1:0] RESP1 = 2'd2;

    typedef struct packed {
        logic [XLEN-1:0] out;
        logic            less;
        logic            zero;
    } alu_rsp_t;

endpackage

// File: rtl/alu_arb_rr_arb2.sv
// rtl/alu_arb_rr_arb2.sv - two-way round-robin arbiter, combinational
// Ports:
//   req  [1:0] in   request vector (bit n = requester n)
//   last       in   requester granted most recently
//   gnt  [1:0] out  one-hot grant (all zero when no request)
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = req;
        // on contention the requester not served last time wins
        if (req == 2'b11) begin
            gnt = last ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/alu_arb.sv
// rtl/alu_arb.sv - arbitrates two requesters onto one combinational ALU, one held result
// Ports:
//   clk, rst (sync, active-high)
//   rN_req_valid/ready/a/b/ctr   operation request from requester N (N=0,1)
//   rN_rsp_valid/ready/out/less/zero   registered result for requester N
//   alu_a/alu_b/alu_ctr out, alu_out/alu_less/alu_zero in   shared ALU
//   grant_cnt0/grant_cnt1/conflict_cnt   only when ALU_ARB_PERF_CNT_EN is defined
// Parameter PRIO_INIT: requester winning the first contended arbitration after reset.
module alu_arb
    import alu_arb_pkg::*;
#(
    parameter logic PRIO_INIT = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
`ifdef ALU_ARB_PERF_CNT_EN
    output logic [31:0]      grant_cnt0,
    output logic [31:0]      grant_cnt1,
    output logic [31:0]      conflict_cnt,
`endif
    input  logic             r0_req_valid,
    output logic             r0_req_ready,
    input  logic [XLEN-1:0]  r0_req_a,
    input  logic [XLEN-1:0]  r0_req_b,
    input  logic [CTR_W-1:0] r0_req_ctr,
    output logic             r0_rsp_valid,
    input  logic             r0_rsp_ready,
    output logic [XLEN-1:0]  r0_rsp_out,
    output logic             r0_rsp_less,
    output logic             r0_rsp_zero,
    input  logic             r1_req_valid,
    output logic             r1_req_ready,
    input  logic [XLEN-1:0]  r1_req_a,
    input  logic [XLEN-1:0]  r1_req_b,
    input  logic [CTR_W-1:0] r1_req_ctr,
    output logic             r1_rsp_valid,
    input  logic             r1_rsp_ready,
    output logic [XLEN-1:0]  r1_rsp_out,
    output logic             r1_rsp_less,
    output logic             r1_rsp_zero,
    output logic [XLEN-1:0]  alu_a,
    output logic [XLEN-1:0]  alu_b,
    output logic [CTR_W-1:0] alu_ctr,
    input  logic [XLEN-1:0]  alu_out,
    input  logic             alu_less,
    input  logic             alu_zero
);

    logic [1:0] state_q, state_d;
    logic       last_q, last_d;
    alu_rsp_t   rsp_q, rsp_d;
    logic       accept;
    logic [1:0] gnt;

    // a slot opens when nothing is held, or the held result leaves this cycle
    assign accept = !rst && ((state_q == IDLE) ||
                             (state_q == RESP0 && r0_rsp_ready) ||
                             (state_q == RESP1 && r1_rsp_ready));

    rr_arb2 u_rr_arb2 (
        .req  ({r1_req_valid, r0_req_valid} & {2{accept}}),
        .last (last_q),
        .gnt  (gnt)
    );

    assign r0_req_ready = gnt[0];
    assign r1_req_ready = gnt[1];

    always_comb begin
        alu_a   = '0;
        alu_b   = '0;
        alu_ctr = '0;
        if (gnt[0]) begin
            alu_a   = r0_req_a;
            alu_b   = r0_req_b;
            alu_ctr = r0_req_ctr;
        end else if (gnt[1]) begin
            alu_a   = r1_req_a;
            alu_b   = r1_req_b;
            alu_ctr = r1_req_ctr;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        rsp_d   = rsp_q;
        if (|gnt) begin
            state_d    = gnt[1] ? RESP1 : RESP0;
            last_d     = gnt[1];
            rsp_d.out  = alu_out;
            rsp_d.less = alu_less;
            rsp_d.zero = alu_zero;
        end else if (accept && state_q != IDLE) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= ~PRIO_INIT;
            rsp_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            rsp_q   <= rsp_d;
        end
    end

    // only the requester owning the held result sees it; the other reads zero
    assign r0_rsp_valid = (state_q == RESP0);
    assign r1_rsp_valid = (state_q == RESP1);
    assign r0_rsp_out   = r0_rsp_valid ? rsp_q.out  : '0;
    assign r0_rsp_less  = r0_rsp_valid & rsp_q.less;
    assign r0_rsp_zero  = r0_rsp_valid & rsp_q.zero;
    assign r1_rsp_out   = r1_rsp_valid ? rsp_q.out  : '0;
    assign r1_rsp_less  = r1_rsp_valid & rsp_q.less;
    assign r1_rsp_zero  = r1_rsp_valid & rsp_q.zero;

`ifdef ALU_ARB_PERF_CNT_EN
    logic [31:0] grant_cnt0_q, grant_cnt0_d;
    logic [31:0] grant_cnt1_q, grant_cnt1_d;
    logic [31:0] conflict_cnt_q, conflict_cnt_d;

    always_comb begin
        grant_cnt0_d   = grant_cnt0_q + {31'd0, gnt[0]};
        grant_cnt1_d   = grant_cnt1_q + {31'd0, gnt[1]};
        conflict_cnt_d = conflict_cnt_q +
                         {31'd0, accept & r0_req_valid & r1_req_valid};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant_cnt0_q   <= '0;
            grant_cnt1_q   <= '0;
            conflict_cnt_q <= '0;
        end else begin
            grant_cnt0_q   <= grant_cnt0_d;
            grant_cnt1_q   <= grant_cnt1_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign grant_cnt0   = grant_cnt0_q;
    assign grant_cnt1   = grant_cnt1_q;
    assign conflict_cnt = conflict_cnt_q;
`endif

endmodule
